// File: rtl/mos6502s_pkg.sv
// rtl/mos6502s_pkg.sv - shared states, source codes, vectors and P-image helpers for interrupt entry
package mos6502s_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_RST0,
      ST_RST1,
      ST_RST2,
      ST_PUSH_PCH,
      ST_PUSH_PCL,
      ST_PUSH_P,
      ST_VEC_LO,
      ST_VEC_HI
   } seq_state_t;

   localparam logic [1:0]  SRC_RESET = 2'd0;
   localparam logic [1:0]  SRC_NMI   = 2'd1;
   localparam logic [1:0]  SRC_IRQ   = 2'd2;
   localparam logic [1:0]  SRC_BRK   = 2'd3;

   localparam logic [15:0] VEC_NMI   = 16'hFFFA;
   localparam logic [15:0] VEC_RESET = 16'hFFFC;
   localparam logic [15:0] VEC_IRQ   = 16'hFFFE;

   localparam int P_B = 4;
   localparam int P_X = 5;

   // A pending NMI steals the vector fetch from BRK/IRQ (hijack)
   function automatic logic [15:0] select_vector(input logic [1:0] src, input logic nmi_pending);
      if (src == SRC_RESET)
         return VEC_RESET;
      else if (src == SRC_NMI || nmi_pending)
         return VEC_NMI;
      else
         return VEC_IRQ;
   endfunction

   function automatic logic [7:0] stacked_p(input logic [7:0] p, input logic is_brk);
      logic [7:0] v;
      v      = p;
      v[P_X] = 1'b1;
      v[P_B] = is_brk;
      return v;
   endfunction

endpackage

// File: rtl/mos6502s_nmi_edge_detect.sv
// rtl/mos6502s_nmi_edge_detect.sv - NMI falling-edge detector with set-priority pending latch
module mos6502s_nmi_edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic i_nmi_n,
   input  logic i_clr,
   output logic o_pending
);

   logic r_nmi_n_q;
   logic r_pending;
   logic w_fall;

   assign w_fall    = r_nmi_n_q & ~i_nmi_n;
   assign o_pending = r_pending;

   // A new edge in the same cycle as the clear is a second NMI and must survive
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_nmi_n_q <= 1'b1;
         r_pending <= 1'b0;
      end else begin
         r_nmi_n_q <= i_nmi_n;
         if (w_fall)
            r_pending <= 1'b1;
         else if (i_clr)
            r_pending <= 1'b0;
      end
   end

endmodule

// File: rtl/mos6502s_interrupt_sequencer.sv
// rtl/mos6502s_interrupt_sequencer.sv - 6502 reset/NMI/BRK/IRQ entry sequencer: stack pushes, vector fetch, PC load
module mos6502s_interrupt_sequencer
   import mos6502s_pkg::*;
#(
   parameter bit         CLEAR_D_ON_INT = 1'b0,
   parameter logic [7:0] STACK_PAGE     = 8'h01
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        instr_boundary,
   input  logic        brk_req,
   input  logic        irq_n,
   input  logic        nmi_n,
   input  logic        i_flag,
   input  logic [7:0]  p_in,
   input  logic [15:0] pc_in,
   input  logic [7:0]  sp_in,
   input  logic        ready,
   input  logic [7:0]  data_in,
   output logic        busy,
   output logic [15:0] addr,
   output logic [7:0]  data_out,
   output logic        we,
   output logic        sp_dec,
   output logic        pc_load,
   output logic [15:0] pc_out,
   output logic        load_i,
   output logic        i_in,
   output logic        load_d,
   output logic        d_in,
   output logic [1:0]  src,
   output logic        done
);

   seq_state_t  r_state, w_state_nxt;
   logic [1:0]  r_src, w_src_nxt;
   logic [7:0]  r_vec_lo, w_vec_lo_nxt;
   logic [15:0] r_vec, w_vec_nxt;
   logic [15:0] w_vec_sel;
   logic [15:0] w_stack_addr;
   logic        w_nmi_pending;
   logic        w_nmi_clr;
   logic        w_enter_vec;

   mos6502s_nmi_edge_detect u_nmi (
      .clk       (clk),
      .rst       (rst),
      .i_nmi_n   (nmi_n),
      .i_clr     (w_nmi_clr),
      .o_pending (w_nmi_pending)
   );

   assign w_stack_addr = {STACK_PAGE, sp_in};
   assign w_vec_sel    = select_vector(r_src, w_nmi_pending);
   assign busy         = (r_state != ST_IDLE) | rst;
   assign pc_out       = {data_in, r_vec_lo};
   assign src          = r_src;
   assign i_in         = 1'b1;
   assign d_in         = 1'b0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= ST_RST0;
         r_src    <= SRC_RESET;
         r_vec_lo <= 8'h00;
         r_vec    <= VEC_RESET;
      end else begin
         r_state  <= w_state_nxt;
         r_src    <= w_src_nxt;
         r_vec_lo <= w_vec_lo_nxt;
         r_vec    <= w_vec_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_src_nxt    = r_src;
      w_vec_lo_nxt = r_vec_lo;
      w_vec_nxt    = r_vec;
      w_enter_vec  = 1'b0;
      w_nmi_clr    = 1'b0;
      addr         = 16'h0000;
      data_out     = 8'h00;
      we           = 1'b0;
      sp_dec       = 1'b0;
      pc_load      = 1'b0;
      load_i       = 1'b0;
      load_d       = 1'b0;
      done         = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (ready && instr_boundary) begin
               if (w_nmi_pending) begin
                  w_src_nxt   = SRC_NMI;
                  w_state_nxt = ST_PUSH_PCH;
               end else if (brk_req) begin
                  w_src_nxt   = SRC_BRK;
                  w_state_nxt = ST_PUSH_PCH;
               end else if (!irq_n && !i_flag) begin
                  w_src_nxt   = SRC_IRQ;
                  w_state_nxt = ST_PUSH_PCH;
               end
            end
         end
         ST_RST0: begin
            addr   = w_stack_addr;
            sp_dec = ready;
            if (ready) w_state_nxt = ST_RST1;
         end
         ST_RST1: begin
            addr   = w_stack_addr;
            sp_dec = ready;
            if (ready) w_state_nxt = ST_RST2;
         end
         ST_RST2: begin
            addr   = w_stack_addr;
            sp_dec = ready;
            if (ready) begin
               w_state_nxt = ST_VEC_LO;
               w_enter_vec = 1'b1;
            end
         end
         ST_PUSH_PCH: begin
            addr     = w_stack_addr;
            data_out = pc_in[15:8];
            we       = ready;
            sp_dec   = ready;
            if (ready) w_state_nxt = ST_PUSH_PCL;
         end
         ST_PUSH_PCL: begin
            addr     = w_stack_addr;
            data_out = pc_in[7:0];
            we       = ready;
            sp_dec   = ready;
            if (ready) w_state_nxt = ST_PUSH_P;
         end
         ST_PUSH_P: begin
            addr     = w_stack_addr;
            data_out = stacked_p(p_in, r_src == SRC_BRK);
            we       = ready;
            sp_dec   = ready;
            if (ready) begin
               w_state_nxt = ST_VEC_LO;
               w_enter_vec = 1'b1;
            end
         end
         ST_VEC_LO: begin
            addr = r_vec;
            if (ready) begin
               w_vec_lo_nxt = data_in;
               w_state_nxt  = ST_VEC_HI;
            end
         end
         ST_VEC_HI: begin
            addr    = r_vec + 16'd1;
            pc_load = ready;
            load_i  = ready;
            load_d  = ready & CLEAR_D_ON_INT;
            done    = ready;
            if (ready) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase

      // Vector is frozen on the edge into VEC_LO so both fetch bytes agree
      if (w_enter_vec) begin
         w_vec_nxt = w_vec_sel;
         if (w_vec_sel == VEC_NMI) begin
            w_src_nxt = SRC_NMI;
            w_nmi_clr = 1'b1;
         end
      end

      if (rst) begin
         we        = 1'b0;
         sp_dec    = 1'b0;
         pc_load   = 1'b0;
         load_i    = 1'b0;
         load_d    = 1'b0;
         done      = 1'b0;
         w_nmi_clr = 1'b0;
      end
   end

endmodule

// File: tb/tb_mos6502s_interrupt_sequencer.sv
// tb/tb_mos6502s_interrupt_sequencer.sv - scenario bench with a transaction-level model of interrupt entry
module tb_mos6502s_interrupt_sequencer;

   localparam logic [1:0] S_RESET = 2'd0;
   localparam logic [1:0] S_NMI   = 2'd1;
   localparam logic [1:0] S_IRQ   = 2'd2;
   localparam logic [1:0] S_BRK   = 2'd3;
   localparam bit         CLR_D   = 1'b1;

   logic        clk, rst, instr_boundary, brk_req, irq_n, nmi_n, i_flag, ready;
   logic [7:0]  p_in, sp_in, data_in, data_out;
   logic [15:0] pc_in, addr, pc_out;
   logic        busy, we, sp_dec, pc_load, load_i, i_in, load_d, d_in, done;
   logic [1:0]  src;

   logic [7:0]  mem [0:65535];
   logic        m_nmi_pend;
   int          n_checks = 0;
   int          n_fail   = 0;

   assign data_in = mem[addr];

   mos6502s_interrupt_sequencer #(.CLEAR_D_ON_INT(CLR_D), .STACK_PAGE(8'h01)) dut (
      .clk(clk), .rst(rst), .instr_boundary(instr_boundary), .brk_req(brk_req),
      .irq_n(irq_n), .nmi_n(nmi_n), .i_flag(i_flag), .p_in(p_in), .pc_in(pc_in),
      .sp_in(sp_in), .ready(ready), .data_in(data_in), .busy(busy), .addr(addr),
      .data_out(data_out), .we(we), .sp_dec(sp_dec), .pc_load(pc_load), .pc_out(pc_out),
      .load_i(load_i), .i_in(i_in), .load_d(load_d), .d_in(d_in), .src(src), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Acts like the core: SP follows every decrement strobe the sequencer issues
   task automatic step();
      logic d;
      d = sp_dec;
      @(posedge clk);
      #1;
      if (d) sp_in = sp_in - 8'd1;
   endtask

   task automatic test_reset();
      logic [63:0] o, e;
      @(negedge clk);
      o = 64'({busy, we, sp_dec, pc_load, load_i, load_d, done, src, i_in, d_in});
      e = 64'({1'b1, 6'b000000, S_RESET, 1'b1, 1'b0});
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL reset_state: got %h want %h", o, e); end
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         o = 64'({busy, addr, we, sp_dec, done});
         e = 64'({1'b1, 8'h01, 8'hFD - 8'(i), 1'b0, 1'b1, 1'b0});
         n_checks++;
         if (o !== e) begin n_fail++; $display("FAIL reset_dummy%0d: got %h want %h", i, o, e); end
         step();
      end
      @(negedge clk);
      o = 64'({busy, addr, we, sp_dec, pc_load});
      e = 64'({1'b1, 16'hFFFC, 3'b000});
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL reset_vec_lo: got %h want %h", o, e); end
      step();
      @(negedge clk);
      o = 64'({addr, pc_load, load_i, load_d, done, pc_out, src});
      e = 64'({16'hFFFD, 1'b1, 1'b1, CLR_D, 1'b1, 16'hC000, S_RESET});
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL reset_vec_hi: got %h want %h", o, e); end
      step();
      @(negedge clk);
      o = 64'({busy, addr, sp_in});
      e = 64'({1'b0, 16'h0000, 8'hFA});
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL reset_idle: got %h want %h", o, e); end
      step();
   endtask

   // Drives one boundary and follows the expected five bus cycles, predicted from the entry rules
   task automatic run_entry(input string tag, input bit nmi_edge, input bit brk, input bit irq_lo,
                            input bit iflag, input logic [15:0] pc, input logic [7:0] p,
                            input logic [7:0] sp, input int nmi_fall_at, input int stall_at,
                            input int stall_len, input bit rnd_ready);
      int          exp_src, idx, ncyc, nstall, stall_left;
      bit          fell, fall_now, ew;
      logic [15:0] vec, ea;
      logic [7:0]  pp, ed;
      logic [1:0]  fin_src;
      logic [63:0] o, e;
      pc_in = pc; p_in = p; sp_in = sp; ready = 1'b1; nmi_n = 1'b1;
      if (nmi_edge) begin
         nmi_n = 1'b0;
         step();
         nmi_n = 1'b1;
         m_nmi_pend = 1'b1;
      end
      brk_req = brk; irq_n = !irq_lo; i_flag = iflag; instr_boundary = 1'b1;
      exp_src = m_nmi_pend ? 1 : brk ? 3 : (irq_lo && !iflag) ? 2 : -1;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL %s boundary_idle: busy=%b want 0", tag, busy); end
      step();
      instr_boundary = 1'b0; brk_req = 1'b0; irq_n = 1'b1;
      if (exp_src < 0) begin
         @(negedge clk);
         n_checks++;
         if (busy !== 1'b0) begin n_fail++; $display("FAIL %s no_entry: busy=%b want 0", tag, busy); end
         step();
         return;
      end
      pp      = {p[7:6], 1'b1, exp_src == 3, p[3:0]};
      fin_src = 2'(exp_src);
      vec     = (exp_src == 1) ? 16'hFFFA : 16'hFFFE;
      idx = 0; ncyc = 0; nstall = 0; stall_left = stall_len; fell = 1'b0;
      while (idx < 5 && ncyc < 40) begin
         if (idx == stall_at && stall_left > 0) begin
            ready = 1'b0;
            stall_left--;
         end else begin
            ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
         end
         fall_now = (idx == nmi_fall_at) && !fell;
         nmi_n    = !fall_now;
         if (fall_now) fell = 1'b1;
         if (idx == 2 && ready && m_nmi_pend) begin
            vec        = 16'hFFFA;
            fin_src    = S_NMI;
            m_nmi_pend = 1'b0;
         end
         ea = (idx < 3) ? {8'h01, sp - 8'(idx)} : (idx == 3) ? vec : vec + 16'd1;
         ed = (idx == 0) ? pc[15:8] : (idx == 1) ? pc[7:0] : (idx == 2) ? pp : 8'h00;
         ew = (idx < 3);
         @(negedge clk);
         if (!ready) begin
            o = 64'({busy, addr, (ew ? data_out : 8'h00), we, sp_dec, pc_load, load_i, load_d, done});
            e = 64'({1'b1, ea, ed, 6'b000000});
         end else if (idx < 4) begin
            o = 64'({busy, addr, (we ? data_out : 8'h00), we, sp_dec, pc_load, done});
            e = 64'({1'b1, ea, ed, ew, ew, 2'b00});
         end else begin
            o = 64'({addr, pc_load, load_i, load_d, done, pc_out, src, sp_dec, we});
            e = 64'({ea, 1'b1, 1'b1, CLR_D, 1'b1, mem[vec + 16'd1], mem[vec], fin_src, 2'b00});
         end
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL %s cycle%0d ready=%b: got %h want %h", tag, idx, ready, o, e);
         end
         if (!ready) nstall++;
         ncyc++;
         step();
         if (fall_now) m_nmi_pend = 1'b1;
         if (ready) idx++;
      end
      ready = 1'b1; nmi_n = 1'b1;
      n_checks++;
      if (idx != 5 || ncyc != 5 + nstall) begin
         n_fail++;
         $display("FAIL %s latency: took %0d cycles for %0d steps, want %0d cycles", tag, ncyc, idx, 5 + nstall);
      end
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL %s release: busy=%b want 0", tag, busy); end
      step();
   endtask

   task automatic test_brk();
      mem[16'hFFFE] = 8'h00;
      mem[16'hFFFF] = 8'h80;
      run_entry("brk", 1'b0, 1'b1, 1'b0, 1'b0, 16'h1236, 8'h20, 8'hFF, -1, -1, 0, 1'b0);
   endtask

   task automatic test_irq();
      run_entry("irq_masked", 1'b0, 1'b0, 1'b1, 1'b1, 16'h4000, 8'h00, 8'hF0, -1, -1, 0, 1'b0);
      run_entry("irq_taken", 1'b0, 1'b0, 1'b1, 1'b0, 16'h4001, 8'hDF, 8'hF0, -1, -1, 0, 1'b0);
   endtask

   task automatic test_nmi_hijack();
      mem[16'hFFFA] = 8'h34;
      mem[16'hFFFB] = 8'h12;
      run_entry("hijack", 1'b0, 1'b1, 1'b0, 1'b1, 16'h2002, 8'h04, 8'hE0, 1, -1, 0, 1'b0);
      run_entry("hijack_cleared", 1'b0, 1'b0, 1'b1, 1'b1, 16'h2002, 8'h04, 8'hE0, -1, -1, 0, 1'b0);
   endtask

   task automatic test_stall();
      run_entry("stall_push_p", 1'b0, 1'b1, 1'b0, 1'b0, 16'hA55A, 8'hC3, 8'h10, -1, 2, 3, 1'b0);
   endtask

   task automatic test_back_to_back();
      logic [63:0] o, e;
      bit          got;
      int          ndec, ncyc;
      logic [15:0] pcv;
      run_entry("simul_nmi", 1'b1, 1'b1, 1'b1, 1'b0, 16'h3003, 8'h81, 8'h40, -1, -1, 0, 1'b0);
      run_entry("simul_brk_next", 1'b0, 1'b1, 1'b1, 1'b0, 16'h3005, 8'h81, 8'h3D, -1, -1, 0, 1'b0);
      pc_in = 16'h7777; sp_in = 8'h90; brk_req = 1'b1; instr_boundary = 1'b1;
      step();
      brk_req = 1'b0; instr_boundary = 1'b0;
      step();
      rst = 1'b1;
      m_nmi_pend = 1'b0;
      #1;
      o = 64'({busy, we, sp_dec, pc_load, load_i, load_d, done, src});
      e = 64'({1'b1, 6'b000000, S_RESET});
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL rst_mid_pcl: got %h want %h", o, e); end
      @(posedge clk);
      #1;
      rst = 1'b0; sp_in = 8'h80;
      got = 1'b0; ndec = 0; ncyc = 0; pcv = 16'h0000;
      while (!got && ncyc < 20) begin
         @(negedge clk);
         if (done) begin
            got = 1'b1;
            pcv = pc_out;
         end else if (sp_dec) begin
            ndec++;
         end
         ncyc++;
         step();
      end
      o = 64'({got, pcv, 8'(ndec), 8'(ncyc)});
      e = 64'({1'b1, 16'hC000, 8'd3, 8'd5});
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL rst_mid_recover: got %h want %h", o, e); end
   endtask

   task automatic test_random();
      for (int n = 0; n < 30; n++) begin
         mem[16'hFFFA] = 8'($urandom);
         mem[16'hFFFB] = 8'($urandom);
         mem[16'hFFFE] = 8'($urandom);
         mem[16'hFFFF] = 8'($urandom);
         run_entry("rand", ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom),
                   8'($urandom), 8'($urandom), int'($urandom_range(0, 7)), -1, 0, 1'b1);
      end
   endtask

   initial begin
      rst = 1'b1; ready = 1'b1; instr_boundary = 1'b0; brk_req = 1'b0;
      irq_n = 1'b1; nmi_n = 1'b1; i_flag = 1'b1;
      p_in = 8'h00; pc_in = 16'h0000; sp_in = 8'hFD; m_nmi_pend = 1'b0;
      mem[16'hFFFA] = 8'h00; mem[16'hFFFB] = 8'h90;
      mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'hC0;
      mem[16'hFFFE] = 8'h00; mem[16'hFFFF] = 8'h80;
      test_reset();
      test_brk();
      test_irq();
      test_nmi_hijack();
      test_stall();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
